// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing source. Registered DrawX/DrawY, blank,
//                hs/vs, frame_start pulse and a free-running frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  // 11-bit compare constants so a full 1024-wide raster still decodes cleanly
  localparam logic [10:0] c_h_vis      = 11'(H_VISIBLE);
  localparam logic [10:0] c_hs_start   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] c_hs_end     = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] c_v_vis      = 11'(V_VISIBLE);
  localparam logic [10:0] c_vs_start   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] c_vs_end     = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  c_h_last     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  c_v_last     = 10'(V_TOTAL - 1);

  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [9:0] drawx_q, drawx_d, drawy_q, drawy_d;
  logic       blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic       fs_q, fs_d, started_q, started_d;
  logic [7:0] fc_q, fc_d;
  logic       w_origin;

  always_comb begin
    hc_d      = hc_q + 10'd1;
    vc_d      = vc_q;
    w_origin  = (hc_q == 10'd0) && (vc_q == 10'd0);
    if (hc_q == c_h_last) begin
      hc_d = 10'd0;
      vc_d = (vc_q == c_v_last) ? 10'd0 : vc_q + 10'd1;
    end
    drawx_d   = hc_q;
    drawy_d   = vc_q;
    blank_d   = ({1'b0, hc_q} < c_h_vis) && ({1'b0, vc_q} < c_v_vis);
    hs_d      = (({1'b0, hc_q} >= c_hs_start) && ({1'b0, hc_q} < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
    vs_d      = (({1'b0, vc_q} >= c_vs_start) && ({1'b0, vc_q} < c_vs_end)) ? SYNC_POL : ~SYNC_POL;
    fs_d      = w_origin;
    // The (0,0) presented right after reset starts frame 0 rather than completing one
    fc_d      = (w_origin && started_q) ? fc_q + 8'd1 : fc_q;
    started_d = started_q | w_origin;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q      <= 10'd0;
      vc_q      <= 10'd0;
      drawx_q   <= 10'd0;
      drawy_q   <= 10'd0;
      blank_q   <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      fs_q      <= 1'b0;
      fc_q      <= 8'd0;
      started_q <= 1'b0;
    end else if (pix_en) begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      drawx_q   <= drawx_d;
      drawy_q   <= drawy_d;
      blank_q   <= blank_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
      fc_q      <= fc_d;
      started_q <= started_d;
    end
  end

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
`default_nettype wire
